// File: rtl/stereo_circ_queue.sv
// Circular stereo sample buffer streaming the newest TAPS samples to the FIR banks.
// Optional sticky trigger-overflow flag: define QUEUE_OVF_FLAG_EN.
module stereo_circ_queue #(
    parameter int DEPTH  = 1024,
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    output logic               seq,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               busy,
    output logic               ovf
);

    localparam int CNT_W = $clog2(TAPS + 1);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_SEQ  = 2'd2;

    localparam logic [CNT_W-1:0]  TAPS_C = CNT_W'(TAPS);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);

    logic [15:0] mem_l [DEPTH];
    logic [15:0] mem_r [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic              pend_q, pend_d;
    logic              seq_q, seq_d;
    logic [15:0]       lft_q, rght_q;
    logic              rd_en;
    logic              start;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        win_d    = win_q;
        pend_d   = pend_q;
        seq_d    = seq_q;
        rd_en    = 1'b0;
        start    = 1'b0;
        wr_ptr_d = wrt_smpl ? wr_ptr_q + 1'b1 : wr_ptr_q;

        unique case (state_q)
            S_FILL: begin
                if (wrt_smpl) begin
                    if (fill_q == TAPS_C - 1'b1) begin
                        fill_d = TAPS_C;
                        start  = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (wrt_smpl || pend_q) start = 1'b1;
            end
            S_SEQ: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (win_q == TAPS_C) begin
                    // window done; a pending trigger restarts after one low cycle
                    seq_d   = 1'b0;
                    state_d = S_IDLE;
                    pend_d  = pend_q | wrt_smpl;
                end else begin
                    rd_en = 1'b1;
                    win_d = win_q + 1'b1;
                    if (wrt_smpl) pend_d = 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase

        if (start) begin
            state_d  = S_SEQ;
            seq_d    = 1'b1;
            win_d    = '0;
            pend_d   = 1'b0;
            rd_ptr_d = wr_ptr_d - TAPS_A;
        end
    end

    always_ff @(posedge clk) begin
        if (wrt_smpl) begin
            mem_l[wr_ptr_q] <= lft_smpl;
            mem_r[wr_ptr_q] <= rght_smpl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            win_q    <= '0;
            pend_q   <= 1'b0;
            seq_q    <= 1'b0;
            lft_q    <= '0;
            rght_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            win_q    <= win_d;
            pend_q   <= pend_d;
            seq_q    <= seq_d;
            if (rd_en) begin
                lft_q  <= mem_l[rd_ptr_q];
                rght_q <= mem_r[rd_ptr_q];
            end
        end
    end

`ifdef QUEUE_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (wrt_smpl && pend_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign seq      = seq_q;
    assign lft_out  = lft_q;
    assign rght_out = rght_q;
    assign busy     = (state_q == S_SEQ);

endmodule

// File: tb/tb_stereo_circ_queue.sv
// Scoreboard bench for stereo_circ_queue with DEPTH=8, TAPS=5.
module tb_stereo_circ_queue;

    localparam int TAPS = 5;

`ifdef QUEUE_OVF_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               wrt_smpl;
    logic signed [15:0] lft_smpl;
    logic signed [15:0] rght_smpl;
    logic               seq;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               busy;
    logic               ovf;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } ent_t;

    ent_t sb[$];
    int   hist[$];
    int   lastv;
    int   total;
    int   pass;
    int   run;
    int   low;
    int   last_gap;
    int   seq_cycles;

    stereo_circ_queue #(
        .DEPTH (8),
        .TAPS  (TAPS),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt_smpl (wrt_smpl),
        .lft_smpl (lft_smpl),
        .rght_smpl(rght_smpl),
        .seq      (seq),
        .lft_out  (lft_out),
        .rght_out (rght_out),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int v);
        lft_smpl  = 16'(v);
        rght_smpl = 16'(-v);
        wrt_smpl  = 1'b1;
        @(posedge clk);
        #1;
        wrt_smpl = 1'b0;
        hist.push_back(v);
    endtask

    // cycle 0 repeats the held output, then the newest TAPS samples oldest first
    task automatic push_win();
        ent_t e;
        int   n;
        n   = hist.size();
        e.l = 16'(lastv);
        e.r = 16'(-lastv);
        sb.push_back(e);
        for (int i = n - TAPS; i < n; i++) begin
            e.l = 16'(hist[i]);
            e.r = 16'(-hist[i]);
            sb.push_back(e);
        end
        lastv = hist[n-1];
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (seq === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (seq !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (seq === 1'b1) pass++;
        else $display("FAIL seq_rise_timeout: got seq=%b required 1", seq);
    endtask

    initial begin
        run        = 0;
        low        = 0;
        last_gap   = 0;
        seq_cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
                low = 0;
            end else if (seq === 1'b1) begin
                if (run == 0) last_gap = low;
                low = 0;
                run++;
                seq_cycles++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL seq_unexpected: got seq=1 required 0");
                end else begin
                    chk("stream", {lft_out, rght_out}, sb.pop_front());
                end
            end else begin
                if (run != 0) chk("seq_len", 32'(run), 32'(TAPS + 1));
                run = 0;
                low++;
            end
        end
    end

    initial begin
        total     = 0;
        pass      = 0;
        lastv     = 0;
        rst_n     = 1'b0;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;

        #3;
        chk("rst_seq", 32'(seq), 32'd0);
        chk("rst_lft", 32'(lft_out), 32'd0);
        chk("rst_rght", 32'(rght_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        idle(2);
        rst_n = 1'b1;

        for (int v = 1; v <= 5; v++) begin
            wr(v);
            if (v < 5) idle(2);
        end
        push_win();
        chk("busy_seq", 32'(busy), 32'd1);
        idle(10);
        chk("busy_idle", 32'(busy), 32'd0);

        for (int v = 6; v <= 12; v++) begin
            wr(v);
            push_win();
            if (v < 12) idle(10);
        end

        idle(2);
        wr(13);
        push_win();

        wait_rise();
        wr(14);
        chk("gap_mid_write", 32'(last_gap), 32'd1);
        idle(1);
        wr(15);
        push_win();
        chk("ovf_double", 32'(ovf), 32'(OVF_EN));

        wait_rise();
        idle(5);
        wr(16);
        push_win();
        chk("seq_gap_low", 32'(seq), 32'd0);
        wait_rise();
        @(negedge clk);
        chk("gap_end_write", 32'(last_gap), 32'd1);
        idle(12);
        chk("busy_idle2", 32'(busy), 32'd0);

        wr(17);
        push_win();
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seq", 32'(seq), 32'd0);
        chk("arst_lft", 32'(lft_out), 32'd0);
        chk("arst_rght", 32'(rght_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        sb.delete();
        hist.delete();
        lastv = 0;
        idle(3);
        rst_n = 1'b1;
        seq_cycles = 0;

        for (int v = 20; v <= 23; v++) begin
            wr(v);
            idle(3);
        end
        idle(8);
        chk("no_seq_refill", 32'(seq_cycles), 32'd0);
        wr(24);
        push_win();
        idle(12);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
